// File: rtl/fifo_tx_serializer_pkg.sv
// ----------------------------------------------------------------------------
// fifo_pkg
//   Shared definitions for the FIFO read-side serial transmitter.
//   - tx_state_t    : 3-bit FSM state encoding. ST_PARITY keeps its code even
//                     when the parity feature is not built, so the encoding
//                     seen on the debug port is stable across builds.
//   - TX_IDLE_LEVEL : line level for idle and stop bit.
//   - TX_START_LEVEL: line level for the start bit.
//   - is_line_state : states in which a serial bit is on the wire and the
//                     baud counter runs.
// ----------------------------------------------------------------------------
package fifo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_START   = 3'd3,
        ST_DATA    = 3'd4,
        ST_PARITY  = 3'd5,
        ST_STOP    = 3'd6
    } tx_state_t;

    localparam logic TX_IDLE_LEVEL  = 1'b1;
    localparam logic TX_START_LEVEL = 1'b0;

    function automatic logic is_line_state(input tx_state_t s);
        return (s == ST_START) || (s == ST_DATA) ||
               (s == ST_PARITY) || (s == ST_STOP);
    endfunction

endpackage

// File: rtl/fifo_tx_serializer_baud_tick_gen.sv
// ----------------------------------------------------------------------------
// baud_tick_gen
//   Bit-period timer for the serial transmitter. Counts 0..CLKS_PER_BIT-1
//   while run is high and wraps to 0 at each bit boundary; held at 0 while
//   run is low so every bit period starts from a clean count.
// Ports
//   clk   in  1  system clock, rising edge
//   rst   in  1  asynchronous, active-high reset
//   run   in  1  count enable; counter clears when low
//   tick  out 1  high in the last cycle of each bit period
// ----------------------------------------------------------------------------
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!run) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Decoded from the count register and the registered run state of the
    // parent, so no input reaches tick combinationally.
    assign tick = run && (r_cnt == LAST);

endmodule

// File: rtl/fifo_tx_serializer.sv
// ----------------------------------------------------------------------------
// fifo_tx_serializer
//   Read-side consumer of a FIFO. Fetches one word at a time and shifts it
//   out LSB-first on an asynchronous serial line:
//   start bit, N data bits, optional even parity bit, stop bit.
//   A read is only issued when the FIFO reports not-empty, so this block can
//   never underflow the FIFO.
// Build option
//   FIFO_TX_PARITY_EN : when defined, an even-parity bit (^word) follows the
//                       data bits. When undefined, DATA goes straight to STOP.
// Ports
//   clk          in   1  system clock, rising edge
//   rst          in   1  asynchronous, active-high reset
//   enable       in   1  permission to start new frames
//   fifo_empty   in   1  FIFO empty flag
//   fifo_data    in   N  FIFO read data, valid the cycle after a read
//   fifo_read    out  1  registered one-cycle read strobe
//   tx           out  1  serial line, idles high
//   busy         out  1  high whenever the FSM is not idle
//   byte_done    out  1  pulse in the last cycle of the stop bit
//   o_dbg_state  out  3  current FSM state (tx_state_t encoding)
// FIFO handshake
//   fifo_read is asserted for exactly one cycle (FETCH) and only after
//   fifo_empty was seen low at the IDLE/STOP decision point; the FIFO samples
//   it at the end of FETCH and drives fifo_data during CAPTURE, which is
//   loaded into the shift register at the end of CAPTURE.
// ----------------------------------------------------------------------------
module fifo_tx_serializer
    import fifo_pkg::*;
#(
    parameter int N            = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic         fifo_empty,
    input  logic [N-1:0] fifo_data,
    output logic         fifo_read,
    output logic         tx,
    output logic         busy,
    output logic         byte_done,
    output logic [2:0]   o_dbg_state
);

    localparam int BW = (N > 1) ? $clog2(N) : 1;

    tx_state_t      r_state;
    logic [N-1:0]   r_shift;
    logic [BW-1:0]  r_bit_idx;
    logic           r_tx;
    logic           r_fifo_read;
    logic           r_busy;
`ifdef FIFO_TX_PARITY_EN
    logic           r_parity;
`endif

    tx_state_t      w_next_state;
    logic           w_tick;
    logic           w_run;
    logic           w_start_ok;
    logic           w_last_bit;

    assign w_run      = is_line_state(r_state);
    assign w_start_ok = enable && !fifo_empty;
    assign w_last_bit = (r_bit_idx == BW'(N - 1));

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .run  (w_run),
        .tick (w_tick)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:    if (w_start_ok) w_next_state = ST_FETCH;
            ST_FETCH:   w_next_state = ST_CAPTURE;
            ST_CAPTURE: w_next_state = ST_START;
            ST_START:   if (w_tick) w_next_state = ST_DATA;
`ifdef FIFO_TX_PARITY_EN
            ST_DATA:    if (w_tick && w_last_bit) w_next_state = ST_PARITY;
            ST_PARITY:  if (w_tick) w_next_state = ST_STOP;
`else
            ST_DATA:    if (w_tick && w_last_bit) w_next_state = ST_STOP;
`endif
            // Back-to-back frames skip IDLE; enable and fifo_empty are only
            // looked at here and in IDLE.
            ST_STOP:    if (w_tick) w_next_state = w_start_ok ? ST_FETCH : ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_bit_idx   <= '0;
            r_tx        <= TX_IDLE_LEVEL;
            r_fifo_read <= 1'b0;
            r_busy      <= 1'b0;
`ifdef FIFO_TX_PARITY_EN
            r_parity    <= 1'b0;
`endif
        end else begin
            r_state     <= w_next_state;
            r_fifo_read <= (w_next_state == ST_FETCH);
            r_busy      <= (w_next_state != ST_IDLE);
            // tx is loaded with the level of the bit about to start, so the
            // line changes exactly on the bit boundary.
            case (r_state)
                ST_CAPTURE: begin
                    r_shift   <= fifo_data;
                    r_tx      <= TX_START_LEVEL;
`ifdef FIFO_TX_PARITY_EN
                    r_parity  <= 1'b0;
`endif
                end
                ST_START: begin
                    if (w_tick) r_tx <= r_shift[0];
                end
                ST_DATA: begin
                    if (w_tick) begin
                        r_shift <= r_shift >> 1;
`ifdef FIFO_TX_PARITY_EN
                        r_parity <= r_parity ^ r_shift[0];
`endif
                        if (w_last_bit) begin
                            r_bit_idx <= '0;
`ifdef FIFO_TX_PARITY_EN
                            r_tx      <= r_parity ^ r_shift[0];
`else
                            r_tx      <= TX_IDLE_LEVEL;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_tx      <= r_shift[1];
                        end
                    end
                end
`ifdef FIFO_TX_PARITY_EN
                ST_PARITY: begin
                    if (w_tick) r_tx <= TX_IDLE_LEVEL;
                end
`endif
                default: ;
            endcase
        end
    end

    assign fifo_read   = r_fifo_read;
    assign tx          = r_tx;
    assign busy        = r_busy;
    // Both operands are flops; the pulse lines up with the final stop cycle.
    assign byte_done   = (r_state == ST_STOP) && w_tick;
    assign o_dbg_state = r_state;

endmodule
